// File: rtl/ebus_xfer_pkg.sv
// Shared EBUS definitions: bus widths, function codes, sequencer states and request payload.
package ebus_xfer_pkg;

    localparam int unsigned EBUS_CS_WIDTH   = 7;
    localparam int unsigned EBUS_FUNC_WIDTH = 3;
    localparam int unsigned EBUS_DATA_WIDTH = 36;
    localparam int unsigned EBUS_TMO_WIDTH  = 8;

    localparam logic [EBUS_FUNC_WIDTH-1:0] EBUS_FUNC_WRITE    = 3'o0;
    localparam logic [EBUS_FUNC_WIDTH-1:0] EBUS_FUNC_READ     = 3'o1;
    localparam logic [EBUS_FUNC_WIDTH-1:0] EBUS_FUNC_PI_SERVE = 3'o4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SETUP,
        ST_DEMAND,
        ST_HOLD,
        ST_RELEASE,
        ST_GAP
    } ebus_xfer_state_t;

    typedef struct packed {
        logic                       write;
        logic [0:EBUS_CS_WIDTH-1]   cs;
        logic [0:EBUS_FUNC_WIDTH-1] func;
        logic [0:EBUS_DATA_WIDTH-1] data;
    } ebus_req_t;

endpackage

// File: rtl/ebus_xfer_timeout.sv
// Demand-phase watchdog: 8-bit cycle counter that flags the last permitted DEMAND cycle.
module ebus_xfer_timeout
    import ebus_xfer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [EBUS_TMO_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + EBUS_TMO_WIDTH'(1);
        end
    end

    // count_q holds the number of DEMAND cycles already spent, so this is the TIMEOUT-th one
    assign expired_c = enable && (count_q == EBUS_TMO_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/ebus_xfer.sv
// EBUS transaction sequencer: turns single-word diagnostic requests into
// arbitrated, timed EBUS cycles with demand/transfer handshake and timeout.
module ebus_xfer
    import ebus_xfer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned GAP     = 1
) (
    input  logic                       eboxClk,
    input  logic                       eboxResetN,
    input  logic                       reqValid,
    output logic                       reqReady,
    input  logic                       reqWrite,
    input  logic [0:EBUS_CS_WIDTH-1]   reqCS,
    input  logic [0:EBUS_FUNC_WIDTH-1] reqFunc,
    input  logic [0:EBUS_DATA_WIDTH-1] reqData,
    output logic                       respValid,
    output logic [0:EBUS_DATA_WIDTH-1] respData,
    output logic                       respTimeout,
    output logic                       ebusReq,
    input  logic                       ebusGrant,
    output logic [0:EBUS_CS_WIDTH-1]   ebusCS,
    output logic [0:EBUS_FUNC_WIDTH-1] ebusFunc,
    output logic                       ebusDemand,
    output logic [0:EBUS_DATA_WIDTH-1] ebusDataOut,
    output logic                       ebusDataOutEn,
    input  logic                       ebusXfer,
    input  logic [0:EBUS_DATA_WIDTH-1] ebusData
);

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

    ebus_xfer_state_t           state_q, state_d;
    ebus_req_t                  req_q, req_d;
    logic                       tmo_flag_q, tmo_flag_d;
    logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;
    logic [0:EBUS_DATA_WIDTH-1] resp_data_d;
    logic                       ready_d;
    logic                       bus_req_d;
    logic                       drive_d;
    logic                       demand_d;
    logic                       tmo_expired_c;

    ebus_xfer_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (eboxClk),
        .rst_n     (eboxResetN),
        .clear     (state_q == ST_SETUP),
        .enable    (state_q == ST_DEMAND),
        .expired_c (tmo_expired_c)
    );

    // Completion must appear in the same RELEASE cycle that sees ebusXfer low,
    // so these two are decoded directly; reset suppresses a pending completion.
    assign respValid   = (state_q == ST_RELEASE) && !ebusXfer && eboxResetN;
    assign respTimeout = respValid && tmo_flag_q;

    // Next state, latched request, and next values of the registered bus outputs
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        tmo_flag_d  = tmo_flag_q;
        gap_cnt_d   = gap_cnt_q;
        resp_data_d = respData;
        ready_d     = 1'b0;
        bus_req_d   = 1'b0;
        drive_d     = 1'b0;
        demand_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (reqValid && reqReady) begin
                    req_d      = '{write: reqWrite, cs: reqCS, func: reqFunc, data: reqData};
                    tmo_flag_d = 1'b0;
                    state_d    = ST_ARB;
                end
            end
            ST_ARB: begin
                if (ebusGrant) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_DEMAND;
            end
            ST_DEMAND: begin
                if (ebusXfer) begin
                    if (!req_q.write) begin
                        resp_data_d = ebusData;
                    end
                    state_d = ST_HOLD;
                end else if (tmo_expired_c) begin
                    tmo_flag_d = 1'b1;
                    state_d    = ST_RELEASE;
                end
            end
            ST_HOLD: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!ebusXfer) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d   = (state_d == ST_IDLE);
        bus_req_d = state_d inside {ST_ARB, ST_SETUP, ST_DEMAND, ST_HOLD, ST_RELEASE};
        drive_d   = state_d inside {ST_SETUP, ST_DEMAND, ST_HOLD, ST_RELEASE};
        demand_d  = state_d inside {ST_DEMAND, ST_HOLD};
    end

    // State and registered outputs; bus outputs follow the state they belong to
    always_ff @(posedge eboxClk) begin
        if (!eboxResetN) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            tmo_flag_q    <= 1'b0;
            gap_cnt_q     <= '0;
            reqReady      <= 1'b1;
            respData      <= '0;
            ebusReq       <= 1'b0;
            ebusCS        <= '0;
            ebusFunc      <= '0;
            ebusDemand    <= 1'b0;
            ebusDataOut   <= '0;
            ebusDataOutEn <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            tmo_flag_q    <= tmo_flag_d;
            gap_cnt_q     <= gap_cnt_d;
            reqReady      <= ready_d;
            respData      <= resp_data_d;
            ebusReq       <= bus_req_d;
            ebusCS        <= drive_d ? req_d.cs : '0;
            ebusFunc      <= drive_d ? req_d.func : '0;
            ebusDemand    <= demand_d;
            ebusDataOut   <= (drive_d && req_d.write) ? req_d.data : '0;
            ebusDataOutEn <= drive_d && req_d.write;
        end
    end

endmodule
